cache_controller: RTL and testbench
===================================

# cache_controller

Direct-mapped, write-through, no-write-allocate cache controller between the RISC-V core's data-memory port and the 5-cycle-latency main memory. It holds 32 lines of 4 words (128-bit blocks). Read hits complete with zero wait. Read misses fetch a whole block. Writes always go to main memory and update the cache line only on a hit. The controller stalls the core while the main-memory handshake is in progress.

## Interface
Parameters:
- LINES, 32: number of cache lines (power of 2). This sets INDEX_W = log2(LINES) and TAG_W = 8 − INDEX_W.
- CNT_W, 16: width of the hit and miss statistics counters.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  10  word address: tag = [9:2+INDEX_W], index = [1+INDEX_W:2], offset = [1:0].
- cpu_wdata  in  32  store data.
- cpu_read  in  1  load request.
- cpu_write  in  1  store request; wins if asserted together with cpu_read.
- cpu_rdata  out  32  load data; valid in the cycle where cpu_read=1 and stall=0.
- stall  out  1  core must hold all cpu_* inputs stable while this is high.
- mem_addr  out  10  word address to main memory.
- mem_wdata  out  32  store data to main memory.
- mem_read  out  1  block read request.
- mem_write  out  1  word write request.
- mem_rdata  in  128  block from memory; word n sits at [32n+31:32n].
- mem_ready  in  1  one-cycle completion pulse from memory.
- hit_count  out  CNT_W  saturating count of read hits.
- miss_count  out  CNT_W  saturating count of read misses.

## Operation
- States: IDLE, FILL, WMEM.
- IDLE, read hit (valid[index] set and tag match):
  - cpu_rdata = cached word; stall=0.
  - hit_count increments.
- IDLE, read miss:
  - stall=1; latch addr into req_addr; go to FILL.
  - miss_count increments.
- IDLE, write:
  - stall=1; latch addr into req_addr and data into req_data; go to WMEM.
  - On a hit, the cached word is updated at this edge. On a miss, the cache is left unchanged.
- IDLE with no request: stall=0.
- FILL:
  - mem_read = !mem_ready; stall = !mem_ready.
  - On mem_ready:
    - write the whole mem_rdata block into data[index], set the tag and valid bit;
    - forward word [offset] of mem_rdata to cpu_rdata;
    - go to IDLE.
- WMEM:
  - mem_write = !mem_ready; stall = !mem_ready.
  - On mem_ready, go to IDLE.
- mem_addr = req_addr and mem_wdata = req_data at all times. They must stay stable through the mem_ready cycle, because mem_rdata is combinational on the address.
- Memory requests are Moore outputs gated by mem_ready. The request is low in the ready cycle so the memory's internal counter does not restart.
- The statistics counters saturate at all-ones.
- Reset (asynchronous, any state, including mid-FILL/WMEM):
  - state=IDLE; all valid bits cleared; counters=0;
  - mem_read=mem_write=0; req_addr=req_data=0.
  - stall, cpu_rdata: stall=0 with no request; cpu_rdata=0 while invalid.
  - Data and tag arrays are not reset.
- After reset the controller makes no assumption about memory latency. It only waits for mem_ready.

## Timing
- A miss or write detected in cycle T0 raises the memory request in T1.
- Memory responds with mem_ready high in T6. Stall is high for T0..T5 and low in T6.
- Load data is forwarded in T6. The core advances at the end of T6.
- Read hit: zero stall, data combinational from the array in the request cycle.
- Back-to-back: a new request in T7 is evaluated in IDLE normally. The refilled line hits from T7.

## Structure
- Package cache_pkg holds:
  - the state enum (IDLE, FILL, WMEM);
  - LINES, INDEX_W, TAG_W, BLOCK_W=128;
  - the address-field slicing constants.
- Sub-module cache_data_array (tag/valid/data storage). It has:
  - asynchronous read;
  - a synchronous full-block fill port and a single-word update port;
  - an asynchronous valid clear on rst_n.

## Test plan
- Preload memory word 0x044 with 0xA0A0_0044 and 0x045 with 0xB1B1_0045. Read 0x045 after reset → stall high for exactly 6 cycles, mem_read for 5 cycles, cpu_rdata=0xB1B1_0045 in the release cycle, miss_count=1.
- Then read 0x044 → zero stall, cpu_rdata=0xA0A0_0044, hit_count=1, mem_read never asserted.
- Write 0x1234_5678 to 0x046 (hit), then read 0x046 → write stalls 6 cycles, memory word 0x046=0x1234_5678, the following read hits with 0x1234_5678.
- Write to 0x0C4 (same index, tag differs, miss) → memory updated. A read of 0x044 still hits the old line with no memory traffic.
- Read 0x0C5 (conflict miss) → line replaced. A later read of 0x045 misses again; miss_count increments.
- Assert rst_n=0 during the 3rd cycle of FILL → mem_read drops immediately, state=IDLE, and a re-read of the same address misses and completes correctly.

Source files
------------

// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Brief  : Shared types and address-field constants for the data cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

   localparam int LINES   = 32;
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = 8 - INDEX_W;
   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;
   localparam int ADDR_W  = 10;
   localparam int OFF_W   = 2;
   localparam int IDX_LSB = OFF_W;
   localparam int TAG_MSB = ADDR_W - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      WMEM = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_data_array.sv
// ============================================================================
// Module : cache_data_array
// Brief  : Tag/valid/data storage; async read, sync block fill and word update.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_data_array
   import cache_pkg::*;
#(
   parameter int LINES = cache_pkg::LINES,
   parameter int IDX_W = $clog2(LINES),
   parameter int TG_W  = ADDR_W - OFF_W - IDX_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic               rd_valid,
   output logic [TG_W-1:0]    rd_tag,
   output logic [BLOCK_W-1:0] rd_block,
   input  logic               fill_en,
   input  logic [IDX_W-1:0]   fill_idx,
   input  logic [TG_W-1:0]    fill_tag,
   input  logic [BLOCK_W-1:0] fill_block,
   input  logic               upd_en,
   input  logic [IDX_W-1:0]   upd_idx,
   input  logic [OFF_W-1:0]   upd_off,
   input  logic [WORD_W-1:0]  upd_word
);

   logic [BLOCK_W-1:0] r_data [LINES];
   logic [TG_W-1:0]    r_tag  [LINES];
   logic [LINES-1:0]   r_valid;

   assign rd_valid = r_valid[rd_idx];
   assign rd_tag   = r_tag[rd_idx];
   assign rd_block = r_data[rd_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (fill_en) begin
         r_valid[fill_idx] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; only the valid bits gate their use.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         r_data[fill_idx] <= fill_block;
         r_tag[fill_idx]  <= fill_tag;
      end else if (upd_en) begin
         r_data[upd_idx][{upd_off, 5'd0} +: WORD_W] <= upd_word;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// Module : cache_controller
// Brief  : Direct-mapped write-through, no-write-allocate data cache controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_controller
   import cache_pkg::*;
#(
   parameter int LINES = cache_pkg::LINES,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         cpu_addr,
   input  logic [31:0]        cpu_wdata,
   input  logic               cpu_read,
   input  logic               cpu_write,
   output logic [31:0]        cpu_rdata,
   output logic               stall,
   output logic [9:0]         mem_addr,
   output logic [31:0]        mem_wdata,
   output logic               mem_read,
   output logic               mem_write,
   input  logic [127:0]       mem_rdata,
   input  logic               mem_ready,
   output logic [CNT_W-1:0]   hit_count,
   output logic [CNT_W-1:0]   miss_count
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TG_W  = ADDR_W - OFF_W - IDX_W;
   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t             r_state, w_next;
   logic [9:0]         r_req_addr;
   logic [31:0]        r_req_data;
   logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt;

   logic [TG_W-1:0]    w_tag;
   logic [IDX_W-1:0]   w_idx;
   logic [OFF_W-1:0]   w_off;
   logic               w_rd_valid;
   logic [TG_W-1:0]    w_rd_tag;
   logic [BLOCK_W-1:0] w_rd_block;
   logic               w_hit;
   logic               w_latch, w_fill_en, w_upd_en, w_hit_inc, w_miss_inc;

   assign w_tag = cpu_addr[TAG_MSB -: TG_W];
   assign w_idx = cpu_addr[IDX_LSB +: IDX_W];
   assign w_off = cpu_addr[OFF_W-1:0];
   assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

   assign mem_addr   = r_req_addr;
   assign mem_wdata  = r_req_data;
   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;

   cache_data_array #(
      .LINES (LINES)
   ) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx     (w_idx),
      .rd_valid   (w_rd_valid),
      .rd_tag     (w_rd_tag),
      .rd_block   (w_rd_block),
      .fill_en    (w_fill_en),
      .fill_idx   (r_req_addr[IDX_LSB +: IDX_W]),
      .fill_tag   (r_req_addr[TAG_MSB -: TG_W]),
      .fill_block (mem_rdata),
      .upd_en     (w_upd_en),
      .upd_idx    (w_idx),
      .upd_off    (w_off),
      .upd_word   (cpu_wdata)
   );

   always_comb begin
      w_next     = r_state;
      stall      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      cpu_rdata  = '0;
      w_latch    = 1'b0;
      w_fill_en  = 1'b0;
      w_upd_en   = 1'b0;
      w_hit_inc  = 1'b0;
      w_miss_inc = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_write) begin
               stall    = 1'b1;
               w_latch  = 1'b1;
               w_upd_en = w_hit;
               w_next   = WMEM;
            end else if (cpu_read) begin
               if (w_hit) begin
                  cpu_rdata = w_rd_block[{w_off, 5'd0} +: WORD_W];
                  w_hit_inc = 1'b1;
               end else begin
                  stall      = 1'b1;
                  w_latch    = 1'b1;
                  w_miss_inc = 1'b1;
                  w_next     = FILL;
               end
            end
         end
         // Request drops in the ready cycle so the memory does not restart.
         FILL: begin
            mem_read = !mem_ready;
            stall    = !mem_ready;
            if (mem_ready) begin
               w_fill_en = 1'b1;
               cpu_rdata = mem_rdata[{r_req_addr[OFF_W-1:0], 5'd0} +: WORD_W];
               w_next    = IDLE;
            end
         end
         WMEM: begin
            mem_write = !mem_ready;
            stall     = !mem_ready;
            if (mem_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_req_addr <= '0;
         r_req_data <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_req_addr <= cpu_addr;
            r_req_data <= cpu_wdata;
         end
         if (w_hit_inc && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + C_ONE;
         end
         if (w_miss_inc && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + C_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// Module : tb_cache_controller
// Brief  : Randomized self-checking bench with a 5-cycle memory and cache model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_controller;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [9:0]    cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic          cpu_read = 1'b0;
   logic          cpu_write = 1'b0;
   logic [31:0]   cpu_rdata;
   logic          stall;
   logic [9:0]    mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_read, mem_write;
   logic [127:0]  mem_rdata;
   logic          mem_ready;
   logic [CW-1:0] hit_count, miss_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cache_controller #(.LINES(32), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
      .stall(stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 'h044) return 32'hA0A0_0044;
      if (i == 'h045) return 32'hB1B1_0045;
      return 32'(32'h9E37_79B9 * (i + 1)) ^ 32'(i);
   endfunction

   // Main memory: ready pulses after five consecutive request cycles.
   logic [31:0] mem [1024];
   bit          loaded = 1'b0;
   int          cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 0;
         mem_ready <= 1'b0;
      end else if (mem_ready) begin
         mem_ready <= 1'b0;
         cnt       <= 0;
      end else if (mem_read || mem_write) begin
         if (cnt == 4) mem_ready <= 1'b1;
         cnt <= cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         loaded <= 1'b1;
      end else if (rst_n && !mem_ready && mem_write && cnt == 4) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_comb begin
      mem_rdata = '0;
      for (int i = 0; i < 4; i++) mem_rdata[32*i +: 32] = mem[{mem_addr[9:2], i[1:0]}];
   end

   // Reference model state
   logic [31:0] ref_mem [1024];
   bit          mv [32];
   logic [2:0]  mt [32];
   logic [31:0] mc [32][4];
   int          m_hit, m_miss;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mv[i] = 1'b0;
      m_hit  = 0;
      m_miss = 0;
   endtask

   task automatic do_op(input bit wr, input bit both, input logic [9:0] a,
                        input logic [31:0] d, output logic [31:0] got);
      logic [4:0] idx;
      logic [2:0] tg;
      logic [1:0] off;
      bit hit, done;
      int cyc, mr, mw, e_cyc, e_mr, e_mw;
      idx = a[6:2];
      tg  = a[9:7];
      off = a[1:0];
      hit = mv[idx] && (mt[idx] == tg);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_write = wr;
      cpu_read  = !wr || both;
      cyc = 0; mr = 0; mw = 0; done = 1'b0; got = '0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_read) begin
            mr++;
            chk("mem_addr_rd", 32'(mem_addr), 32'(a));
         end
         if (mem_write) begin
            mw++;
            chk("mem_addr_wr", 32'(mem_addr), 32'(a));
            chk("mem_wdata", mem_wdata, d);
         end
         if (!stall) begin
            done = 1'b1;
            got  = cpu_rdata;
         end
         @(posedge clk); #1;
      end
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      if (wr)       begin e_cyc = 7; e_mr = 0; e_mw = 5; end
      else if (hit) begin e_cyc = 1; e_mr = 0; e_mw = 0; end
      else          begin e_cyc = 7; e_mr = 5; e_mw = 0; end
      chk("stall_cycles", 32'(cyc), 32'(e_cyc));
      chk("mem_read_cycles", 32'(mr), 32'(e_mr));
      chk("mem_write_cycles", 32'(mw), 32'(e_mw));
      if (!wr) begin
         chk("cpu_rdata", got, hit ? mc[idx][off] : ref_mem[a]);
         if (hit) begin
            if (m_hit < (1 << CW) - 1) m_hit++;
         end else begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            for (int w = 0; w < 4; w++) mc[idx][w] = ref_mem[{a[9:2], 2'(w)}];
            if (m_miss < (1 << CW) - 1) m_miss++;
         end
      end else begin
         ref_mem[a] = d;
         if (hit) mc[idx][off] = d;
         chk("mem_word", mem[a], d);
      end
      chk("hit_count", 32'(hit_count), 32'(m_hit));
      chk("miss_count", 32'(miss_count), 32'(m_miss));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_stall", 32'(stall), 32'd0);
         chk("idle_mem_req", 32'({mem_read, mem_write}), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [9:0]  a;
      bit          wr;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req", 32'({mem_read, mem_write}), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_counts", 32'({hit_count, miss_count}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(1'b0, 1'b0, 10'h045, 32'd0, got);
      chk("lit_rd045", got, 32'hB1B1_0045);
      chk("lit_miss1", 32'(miss_count), 32'd1);
      do_op(1'b0, 1'b0, 10'h044, 32'd0, got);
      chk("lit_rd044", got, 32'hA0A0_0044);
      chk("lit_hit1", 32'(hit_count), 32'd1);
      do_op(1'b1, 1'b0, 10'h046, 32'h1234_5678, got);
      chk("lit_mem046", mem[10'h046], 32'h1234_5678);
      do_op(1'b0, 1'b0, 10'h046, 32'd0, got);
      chk("lit_rd046", got, 32'h1234_5678);
      do_op(1'b1, 1'b1, 10'h0C4, 32'hCAFE_00C4, got);
      chk("lit_mem0c4", mem[10'h0C4], 32'hCAFE_00C4);
      do_op(1'b0, 1'b0, 10'h044, 32'd0, got);
      chk("lit_rd044_again", got, 32'hA0A0_0044);
      do_op(1'b0, 1'b0, 10'h0C5, 32'd0, got);
      do_op(1'b0, 1'b0, 10'h045, 32'd0, got);
      chk("lit_miss3", 32'(miss_count), 32'd3);
      idle(2);

      // Reset during the third FILL cycle of a conflict miss.
      cpu_addr = 10'h0C5;
      cpu_read = 1'b1;
      @(negedge clk);
      chk("fill_t0_stall", 32'(stall), 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("fill_t3_mem_read", 32'(mem_read), 32'd1);
      #1;
      rst_n    = 1'b0;
      cpu_read = 1'b0;
      #1;
      chk("arst_mem_read", 32'(mem_read), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_counts", 32'({hit_count, miss_count}), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(1'b0, 1'b0, 10'h0C5, 32'd0, got);
      chk("lit_rd0c5_after_rst", got, init_word('h0C5));
      chk("lit_miss_after_rst", 32'(miss_count), 32'd1);

      for (int n = 0; n < 400; n++) begin
         a  = {3'($urandom_range(0, 2)), 5'($urandom_range(16, 19)), 2'($urandom)};
         wr = ($urandom_range(0, 3) == 0);
         do_op(wr, wr && ($urandom_range(0, 1) == 1), a, $urandom, got);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
